// File: rtl/ifio_stage_fifo.sv
// ifio_stage_fifo: elastic buffer between the autoinst_iface270_sub producer and
// the ifio consumer stage. It has a valid/ready handshake on both sides, reports
// occupancy, and keeps a high-water mark used to size the buffer.
//
// Handshake rules:
// - The head word comes straight from storage at the read pointer. A pushed word
//   becomes visible one cycle after it is accepted, and there is no
//   combinational path from the input side to the output side.
// - in_ready depends only on registered occupancy. A full buffer refuses a push
//   even when a pop happens in the same cycle; this keeps the ready path short.
module ifio_stage_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   hwm,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    // Pointers keep at least one bit so that a single-entry buffer still has a
    // legal index. The wrap test below keeps them inside 0..DEPTH-1.
    localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    // Advance a pointer modulo DEPTH. For power-of-two depths this is the
    // natural wrap; the explicit compare also covers DEPTH == 1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Pick the larger of two occupancy values; the high-water mark uses this.
    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] hwm_q,    hwm_d;

    logic full_w;
    logic empty_w;
    logic push;
    logic pop;

    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);

    // Handshakes are qualified only by registered occupancy. On an empty buffer
    // out_valid is low, so out_ready has no effect.
    assign push = in_valid & ~full_w;
    assign pop  = ~empty_w & out_ready;

    // Next-state logic for the pointers, the occupancy and the high-water mark.
    // Flush discards the contents and any transfer in the same cycle. It clears
    // count to zero, so the max() leaves the high-water mark unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        hwm_d = cnt_max(hwm_q, count_d);
    end

    // Control state register. Reset has priority over flush and also clears
    // the high-water mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Word storage is not reset. A word written in a cycle that also flushes
    // or resets is harmless, because the pointers move away from it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = ~full_w;
    assign out_valid = ~empty_w;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign hwm       = hwm_q;
    assign full      = full_w;
    assign empty     = empty_w;

endmodule

// File: tb/tb_ifio_stage_fifo.sv
// Testbench for ifio_stage_fifo (WIDTH=32, DEPTH_LOG2=2). It runs directed
// scenarios and then a randomized run. A queue-based reference model provides
// the expected behaviour.
module tb_ifio_stage_fifo;

    localparam int WIDTH      = 32;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [DEPTH_LOG2:0] count;
    logic [DEPTH_LOG2:0] hwm;
    logic                full;
    logic                empty;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: contents in arrival order plus the high-water mark.
    logic [WIDTH-1:0] mq[$];
    int               mhwm;

    ifio_stage_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .hwm       (hwm),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Update the model from the current inputs, then advance one clock edge
    // and let the outputs settle.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        if (rst) begin
            mq.delete();
            mhwm = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
            if (mq.size() > mhwm) mhwm = mq.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests_run++; if (hwm !== 3'd0) begin tests_failed++; $display("FAIL reset_hwm got=%0d exp=0", hwm); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++; if (full !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL reset_flags got full=%b empty=%b exp full=0 empty=1", full, empty); end
    endtask

    // Four pushes with the consumer stalled fill the buffer; a fifth is refused.
    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + i;
            cycle();
            tests_run++; if (count !== 3'(i + 1)) begin tests_failed++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
        end
        tests_run++; if (full !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full got full=%b in_ready=%b exp full=1 in_ready=0", full, in_ready); end
        tests_run++; if (hwm !== 3'd4) begin tests_failed++; $display("FAIL fill_hwm got=%0d exp=4", hwm); end
        tests_run++; if (out_data !== 32'hA0) begin tests_failed++; $display("FAIL fill_head got=%h exp=000000a0", out_data); end
        in_data = 32'hA4;
        cycle();
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL fill_fifth_refused count got=%0d exp=4", count); end
        in_valid = 1'b0;
    endtask

    // Starting from full, the four words come out in order and the buffer
    // ends empty.
    task automatic test_drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + i) begin tests_failed++; $display("FAIL drain_word[%0d] got vld=%b data=%h exp vld=1 data=%h", i, out_valid, out_data, 32'hA0 + i); end
            cycle();
        end
        tests_run++; if (empty !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got empty=%b out_valid=%b exp 1/0", empty, out_valid); end
        tests_run++; if (hwm !== 3'd4) begin tests_failed++; $display("FAIL drain_hwm got=%0d exp=4", hwm); end
        out_ready = 1'b0;
    endtask

    // With both sides always ready, occupancy stays at one and every word
    // appears exactly one cycle after it is pushed.
    task automatic test_back_to_back();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'hB0 + i;
            cycle();
            tests_run++; if (count !== 3'd1 || out_valid !== 1'b1 || out_data !== 32'hB0 + i) begin tests_failed++; $display("FAIL stream[%0d] got cnt=%0d data=%h exp cnt=1 data=%h", i, count, out_data, 32'hB0 + i); end
        end
        in_valid = 1'b0;
        cycle();
        tests_run++; if (count !== 3'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL stream_drained got cnt=%0d exp=0", count); end
        out_ready = 1'b0;
    endtask

    // A full buffer pops but refuses a push in the same cycle; the refused
    // word never appears.
    task automatic test_full_push_pop();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hC0 + i;
            cycle();
        end
        in_data   = 32'hC4;
        out_ready = 1'b1;
        cycle();
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL fullpp_count got=%0d exp=3", count); end
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tests_run++; if (out_data !== 32'hC0 + i) begin tests_failed++; $display("FAIL fullpp_word[%0d] got=%h exp=%h", i, out_data, 32'hC0 + i); end
            cycle();
        end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL fullpp_empty got=%b exp=1", empty); end
        out_ready = 1'b0;
    endtask

    // Flush empties the buffer and discards the push in the same cycle, but
    // keeps the high-water mark.
    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hD0 + i;
            cycle();
        end
        flush     = 1'b1;
        in_data   = 32'hD3;
        out_ready = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++; if (count !== 3'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL flush_count got cnt=%0d empty=%b exp 0/1", count, empty); end
        tests_run++; if (hwm !== 3'd3) begin tests_failed++; $display("FAIL flush_hwm got=%0d exp=3", hwm); end
        cycle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_ghost got out_valid=%b exp=0", out_valid); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hE0;
        cycle();
        in_valid = 1'b0;
        tests_run++; if (count !== 3'd1 || out_data !== 32'hE0) begin tests_failed++; $display("FAIL flush_after got cnt=%0d data=%h exp 1/000000e0", count, out_data); end
    endtask

    // Reset during a push and pop clears everything, including the
    // high-water mark.
    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'hF0 + i;
            cycle();
        end
        rst       = 1'b1;
        in_data   = 32'hF2;
        out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        tests_run++; if (count !== 3'd0 || hwm !== 3'd0) begin tests_failed++; $display("FAIL rstmid got cnt=%0d hwm=%0d exp 0/0", count, hwm); end
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_hs got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
        idle_inputs();
    endtask

    // Random traffic, with occasional flushes and resets, checked against the
    // model every cycle.
    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 31) == 0);
            // Keep in_data stable while the producer is stalled.
            if (!(in_valid && mq.size() == DEPTH)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            tests_run++;
            if (count !== 3'(mq.size()) || hwm !== 3'(mhwm) ||
                out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH) ||
                full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
                (mq.size() > 0 && out_data !== mq[0])) begin
                tests_failed++;
                if (errs < 10) $display("FAIL random[%0d] got cnt=%0d hwm=%0d data=%h exp cnt=%0d hwm=%0d data=%h",
                                        c, count, hwm, out_data, mq.size(), mhwm, (mq.size() > 0) ? mq[0] : '0);
                errs++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        mhwm = 0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
